// File: rtl/frame_capture.sv
// Sink for a raster pixel stream: requests one frame, accepts every pixel and
// writes a rectangular window into a linear row-major buffer.
module frame_capture #(
    parameter int FRAME_W = 800,
    parameter int FRAME_H = 600,
    parameter int WIN_X   = 300,
    parameter int WIN_Y   = 225,
    parameter int WIN_W   = 200,
    parameter int WIN_H   = 150,
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              capture,
    input  logic              stall,
    output logic              start,
    input  logic              start_ack,
    input  logic              valid,
    input  logic [7:0]        pixel,
    output logic              ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [9:0]        COL_LAST = 10'(FRAME_W - 1);
    localparam logic [9:0]        ROW_LAST = 10'(FRAME_H - 1);
    localparam logic [9:0]        X_LO     = 10'(WIN_X);
    localparam logic [9:0]        X_HI     = 10'(WIN_X + WIN_W);
    localparam logic [9:0]        Y_LO     = 10'(WIN_Y);
    localparam logic [9:0]        Y_HI     = 10'(WIN_Y + WIN_H);
    localparam logic [TCNT_W-1:0] TO_LAST  = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ACKLO = 2'd2,
        S_RECV  = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [9:0]        row;
    logic [9:0]        col;
    logic [ADDR_W-1:0] idx;
    logic [TCNT_W-1:0] tcnt;

    logic xfer;
    logic last_px;
    logic hit;
    logic tick;
    logic abort;

    // Pixel handshake: a pixel moves on a rising clock edge exactly when valid
    // and ready are both high; ready never depends on valid, and the source must
    // hold pixel stable while valid is high and ready is low.
    always_comb begin
        next_state = state;
        start      = (state == S_REQ);
        ready      = (state == S_RECV) && !stall;
        busy       = (state != S_IDLE);
        dbg_state  = state;
        xfer       = ready && valid;
        last_px    = (row == ROW_LAST) && (col == COL_LAST);
        hit        = (col >= X_LO) && (col < X_HI) && (row >= Y_LO) && (row < Y_HI);

        case (state)
            S_IDLE:  if (capture)          next_state = S_REQ;
            S_REQ:   if (start_ack)        next_state = S_ACKLO;
            S_ACKLO: if (!start_ack)       next_state = S_RECV;
            S_RECV:  if (xfer && last_px)  next_state = S_IDLE;
            default:                       next_state = S_IDLE;
        endcase

        // Idle cycles only accumulate while the state is holding and nothing moved.
        tick  = busy && (next_state == state) && !xfer;
        abort = tick && (tcnt == TO_LAST);
        if (abort) begin
            next_state = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row     <= '0;
            col     <= '0;
            idx     <= '0;
            tcnt    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= xfer && last_px;
            err  <= abort;

            if (next_state != state) begin
                tcnt <= '0;
            end else if (xfer) begin
                tcnt <= '0;
            end else if (busy) begin
                tcnt <= tcnt + 1'b1;
            end

            if (state == S_ACKLO && next_state == S_RECV) begin
                row <= '0;
                col <= '0;
            end else if (xfer) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            // The write address is the running count of window pixels this frame.
            if (state == S_ACKLO && next_state == S_RECV) begin
                idx   <= '0;
                wr_en <= 1'b0;
            end else if (xfer && hit) begin
                wr_en   <= 1'b1;
                wr_data <= pixel;
                wr_addr <= idx;
                idx     <= idx + 1'b1;
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_capture.sv
// Directed/random bench for frame_capture on a reduced frame geometry, with a
// pixel source model and a window scoreboard derived from frame contents.
module tb_frame_capture;

    localparam int FRAME_W = 40;
    localparam int FRAME_H = 30;
    localparam int WIN_X   = 15;
    localparam int WIN_Y   = 11;
    localparam int WIN_W   = 10;
    localparam int WIN_H   = 8;
    localparam int ADDR_W  = 7;
    localparam int TIMEOUT = 64;
    localparam int TOTAL   = FRAME_W * FRAME_H;
    localparam int NWIN    = WIN_W * WIN_H;
    localparam int ACK_DLY = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              capture = 1'b0;
    logic              stall = 1'b0;
    logic              start;
    logic              start_ack = 1'b0;
    logic              valid = 1'b0;
    logic [7:0]        pixel = 8'h00;
    logic              ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        dbg_state;

    frame_capture #(
        .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .WIN_X(WIN_X), .WIN_Y(WIN_Y),
        .WIN_W(WIN_W), .WIN_H(WIN_H), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .capture(capture), .stall(stall),
        .start(start), .start_ack(start_ack), .valid(valid), .pixel(pixel),
        .ready(ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [7:0]        frame_mem [TOTAL];
    logic [7:0]        buf_mem   [1 << ADDR_W];
    logic [ADDR_W+7:0] exp_q[$];

    bit ack_en     = 1'b1;
    bit stall_en   = 1'b0;
    bit valid_rand = 1'b0;
    bit src_rst    = 1'b0;
    int src_pos    = 0;
    int stall_viol = 0;
    int start_cnt  = 0;
    int done_cnt   = 0;
    int err_cnt    = 0;
    int wr_cnt     = 0;
    int last_addr  = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Source model: acks a request after ACK_DLY cycles, streams the frame after
    // releasing the ack, and advances only on cycles where valid & ready held.
    initial begin : source
        bit active;
        bit xfer_next;
        int ack_cnt;
        active = 1'b0;
        xfer_next = 1'b0;
        ack_cnt = 0;
        forever begin
            @(negedge clock);
            if (src_rst) begin
                active = 1'b0; xfer_next = 1'b0; ack_cnt = 0; src_pos = 0;
                start_ack = 1'b0; valid = 1'b0; stall = 1'b0;
            end else begin
                if (xfer_next) begin
                    src_pos++;
                    if (src_pos == TOTAL) active = 1'b0;
                end
                if (!active) begin
                    if (start && ack_en && !start_ack) begin
                        ack_cnt++;
                        if (ack_cnt >= ACK_DLY) start_ack = 1'b1;
                    end else if (!start && start_ack) begin
                        start_ack = 1'b0; active = 1'b1; src_pos = 0; ack_cnt = 0;
                    end
                end
                stall = stall_en ? ($urandom_range(0, 99) < 30) : 1'b0;
                valid = active && (valid_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
                pixel = (active && src_pos < TOTAL) ? frame_mem[src_pos] : 8'($urandom);
            end
            #1;
            xfer_next = valid && ready;
            if (stall && ready) stall_viol++;
        end
    end

    // Output monitor and write scoreboard.
    initial begin : monitor
        logic [ADDR_W+7:0] e;
        forever begin
            @(negedge clock);
            #1;
            if (start) start_cnt++;
            if (done)  done_cnt++;
            if (err)   err_cnt++;
            if (wr_en) begin
                wr_cnt++;
                last_addr = int'(wr_addr);
                buf_mem[wr_addr] = wr_data;
                check("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+7:8]));
                    check("wr_data", 32'(wr_data), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic pulse_capture();
        @(negedge clock); capture = 1'b1;
        @(negedge clock); capture = 1'b0;
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 32'(start), 0);
        check({tag, "_ready"}, 32'(ready), 0);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    task automatic run_frame(input bit st, input bit vr, input bit pat, input bit mid);
        int cyc;
        int done0;
        int err0;
        bit mid_state;
        for (int r = 0; r < FRAME_H; r++)
            for (int c = 0; c < FRAME_W; c++)
                frame_mem[r*FRAME_W + c] = pat ? 8'(r ^ c) : 8'($urandom);
        exp_q.delete();
        for (int a = 0; a < NWIN; a++)
            exp_q.push_back({ADDR_W'(a), frame_mem[(WIN_Y + a / WIN_W) * FRAME_W + WIN_X + a % WIN_W]});
        stall_en = st; valid_rand = vr;
        wr_cnt = 0; start_cnt = 0; stall_viol = 0; last_addr = -1;
        done0 = done_cnt; err0 = err_cnt;
        mid_state = 1'b0;
        pulse_capture();
        check("busy_after_capture", 32'(busy), 1);
        cyc = 0;
        while (done_cnt == done0 && cyc < 20000) begin
            @(negedge clock); #2; cyc++;
            if (mid && !mid_state && src_pos >= TOTAL / 2) begin
                capture = 1'b1; mid_state = 1'b1;
            end else begin
                capture = 1'b0;
            end
        end
        capture = 1'b0;
        check("done_seen", 32'(done_cnt - done0), 1);
        check("xfers_at_done", 32'(src_pos), TOTAL);
        check("write_count", 32'(wr_cnt), NWIN);
        check("exp_q_drained", 32'(exp_q.size()), 0);
        check("last_addr", 32'(last_addr), NWIN - 1);
        check("start_high_2_to_3", 32'(start_cnt >= ACK_DLY && start_cnt <= ACK_DLY + 1), 1);
        check("no_ready_under_stall", 32'(stall_viol), 0);
        repeat (6) @(negedge clock);
        #2;
        check("idle_after_frame", 32'(busy), 0);
        check("single_done", 32'(done_cnt - done0), 1);
        check("no_err_in_frame", 32'(err_cnt - err0), 0);
        stall_en = 1'b0; valid_rand = 1'b0;
    endtask

    initial begin : main
        int cyc;
        int a;
        int err0;
        int done0;

        // Reset state
        repeat (3) @(negedge clock);
        #2;
        check_all_zero("reset");
        @(negedge clock); reset = 1'b1;
        repeat (2) @(negedge clock);
        #2;
        check("idle_busy", 32'(busy), 0);

        // Random pixels, continuous flow
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);

        // Pattern pixels: buffer contents follow the window coordinates
        for (int i = 0; i < (1 << ADDR_W); i++) buf_mem[i] = 8'hxx;
        run_frame(1'b0, 1'b0, 1'b1, 1'b0);
        check("buf_addr0", 32'(buf_mem[0]), 32'(8'(WIN_X ^ WIN_Y)));
        for (int k = 0; k < 3; k++) begin
            a = $urandom_range(0, NWIN - 1);
            check("buf_pattern", 32'(buf_mem[a]),
                  32'(8'((WIN_X + a % WIN_W) ^ (WIN_Y + a / WIN_W))));
        end
        check("buf_last", 32'(buf_mem[NWIN-1]),
              32'(8'((WIN_X + WIN_W - 1) ^ (WIN_Y + WIN_H - 1))));

        // Random stall and random valid gaps
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);

        // Request never acknowledged: timeout abort
        ack_en = 1'b0;
        err0 = err_cnt; done0 = done_cnt;
        pulse_capture();
        check("req_start_high", 32'(start), 1);
        cyc = 0;
        while (!err && cyc < TIMEOUT + 20) begin
            @(negedge clock); #2; cyc++;
        end
        check("timeout_cycles", 32'(cyc), TIMEOUT);
        check("timeout_start_low", 32'(start), 0);
        check("timeout_ready_low", 32'(ready), 0);
        check("timeout_idle", 32'(busy), 0);
        @(negedge clock); #2;
        check("err_one_cycle", 32'(err), 0);
        check("err_count", 32'(err_cnt - err0), 1);
        check("no_done_on_abort", 32'(done_cnt - done0), 0);
        ack_en = 1'b1;

        // Capture re-pulsed mid-frame is ignored, then a fresh capture works
        run_frame(1'b0, 1'b1, 1'b0, 1'b1);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame, then restart from address 0
        for (int r = 0; r < FRAME_H; r++)
            for (int c = 0; c < FRAME_W; c++)
                frame_mem[r*FRAME_W + c] = 8'($urandom);
        exp_q.delete();
        for (int i = 0; i < NWIN; i++)
            exp_q.push_back({ADDR_W'(i), frame_mem[(WIN_Y + i / WIN_W) * FRAME_W + WIN_X + i % WIN_W]});
        pulse_capture();
        cyc = 0;
        while (src_pos < 15 * FRAME_W && cyc < 5000) begin
            @(negedge clock); #2; cyc++;
        end
        check("reached_mid_frame", 32'(src_pos >= 15 * FRAME_W), 1);
        #1;
        reset = 1'b0; src_rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #2;
        src_rst = 1'b0;
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
